// File: rtl/alu_pkg.sv
// Shared opcode values, BIST state encoding and the opcode sweep order for alu_bist.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic [2:0] next_op(input logic [2:0] op);
    case (op)
      ALU_AND: next_op = ALU_OR;
      ALU_OR:  next_op = ALU_ADD;
      ALU_ADD: next_op = ALU_SUB;
      ALU_SUB: next_op = ALU_SLT;
      default: next_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_bist_ref.sv
// Combinational golden model of the alu: result plus zero, signed-overflow and carry/borrow flags.
module alu_bist_ref
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] r,
  output logic                  zero,
  output logic                  ovf,
  output logic                  carry
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]          sum;
  logic [DATA_WIDTH:0]          diff;
  logic signed [DATA_WIDTH-1:0] sa;
  logic signed [DATA_WIDTH-1:0] sb;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    sa    = $signed(a);
    sb    = $signed(b);
    r     = '0;
    ovf   = 1'b0;
    carry = 1'b0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: begin
        r     = sum[MSB:0];
        carry = sum[DATA_WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // Top bit of the widened difference is the unsigned borrow (a < b).
        r     = diff[MSB:0];
        carry = diff[DATA_WIDTH];
        ovf   = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      ALU_SLT: r = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      default: r = '0;
    endcase
    zero = (r == '0);
  end

endmodule

// File: rtl/alu_bist.sv
// Self-test engine that sweeps every opcode and A/B pair through the alu and checks each response.
// Optional macro ALU_BIST_FLAG_CHECK_EN adds Overflow/CarryOut comparison for ADD and SUB.
module alu_bist
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Zero,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [DATA_WIDTH-1:0] fail_A,
  output logic [DATA_WIDTH-1:0] fail_B,
  output logic [2:0]            fail_op,
  output logic [DATA_WIDTH-1:0] fail_result
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t                  state;
  logic [SCW-1:0]          settle_cnt;
  logic [DATA_WIDTH-1:0]   ref_r;
  logic                    ref_zero;
  logic                    ref_ovf;
  logic                    ref_carry;
  logic                    mism;
  logic                    last_vec;

  alu_bist_ref #(.DATA_WIDTH(DATA_WIDTH)) u_ref (
    .a     (alu_A),
    .b     (alu_B),
    .op    (alu_ALUop),
    .r     (ref_r),
    .zero  (ref_zero),
    .ovf   (ref_ovf),
    .carry (ref_carry)
  );

`ifdef ALU_BIST_FLAG_CHECK_EN
  always_comb begin
    mism = (alu_Result != ref_r) || (alu_Zero != ref_zero);
    if ((alu_ALUop == ALU_ADD) || (alu_ALUop == ALU_SUB))
      mism = mism || (alu_Overflow != ref_ovf) || (alu_CarryOut != ref_carry);
  end
`else
  logic unused_flags;
  assign unused_flags = ^{alu_Overflow, alu_CarryOut, ref_ovf, ref_carry};

  always_comb begin
    mism = (alu_Result != ref_r) || (alu_Zero != ref_zero);
  end
`endif

  assign last_vec = (alu_ALUop == ALU_SLT) && (&alu_A) && (&alu_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_ALUop   <= ALU_AND;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_A      <= '0;
      fail_B      <= '0;
      fail_op     <= '0;
      fail_result <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_DRIVE;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_ALUop   <= ALU_AND;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_A      <= '0;
            fail_B      <= '0;
            fail_op     <= '0;
            fail_result <= '0;
          end
        end
        ST_DRIVE: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SCW'(SETTLE_CYCLES - 1))
            state <= ST_CHECK;
          else
            settle_cnt <= settle_cnt + 1'b1;
        end
        ST_CHECK: begin
          if (mism) begin
            if (err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
            // Only the very first failing vector is kept for diagnosis.
            if (err_count == 16'd0) begin
              fail_A      <= alu_A;
              fail_B      <= alu_B;
              fail_op     <= alu_ALUop;
              fail_result <= alu_Result;
            end
          end
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0) && !mism;
          end else begin
            state <= ST_DRIVE;
            alu_A <= alu_A + 1'b1;
            if (&alu_A) begin
              alu_B <= alu_B + 1'b1;
              if (&alu_B)
                alu_ALUop <= next_op(alu_ALUop);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a behavioural alu with per-vector fault injection plus an arithmetic reference.
module tb_alu_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] alu_A, alu_B, alu_Result;
  logic [2:0] alu_ALUop;
  logic       alu_Zero, alu_Overflow, alu_CarryOut;
  logic       busy, done, pass;
  logic [15:0] err_count;
  logic [3:0] fail_A, fail_B, fail_result;
  logic [2:0] fail_op;

  int checks = 0;
  int errors = 0;

  logic       force_en  [1280];
  logic [3:0] force_val [1280];
  logic       carry_inv;

  always #5 clk = ~clk;

  alu_bist #(.DATA_WIDTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Zero(alu_Zero),
    .alu_Overflow(alu_Overflow), .alu_CarryOut(alu_CarryOut),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_A(fail_A), .fail_B(fail_B), .fail_op(fail_op), .fail_result(fail_result)
  );

  function automatic int op_index(input logic [2:0] op);
    case (op)
      3'b000: return 0;
      3'b001: return 1;
      3'b010: return 2;
      3'b110: return 3;
      3'b111: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int op_code(input int opi);
    case (opi)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic int sx(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int gold_r(input int opi, input int a, input int b);
    case (opi)
      0: return a & b;
      1: return a | b;
      2: return (a + b) % 16;
      3: return (a - b + 16) % 16;
      default: return (sx(a) < sx(b)) ? 1 : 0;
    endcase
  endfunction

  function automatic int gold_c(input int opi, input int a, input int b);
    if (opi == 2) return (a + b > 15) ? 1 : 0;
    if (opi == 3) return (a < b) ? 1 : 0;
    return 0;
  endfunction

  function automatic int gold_v(input int opi, input int a, input int b);
    int s;
    if (opi == 2) s = sx(a) + sx(b);
    else if (opi == 3) s = sx(a) - sx(b);
    else return 0;
    return (s < -8 || s > 7) ? 1 : 0;
  endfunction

  // Behavioural alu under test, with optional per-vector result override.
  int alu_opi, alu_idx, alu_r;
  always_comb begin
    alu_opi      = op_index(alu_ALUop);
    alu_idx      = 0;
    alu_r        = 0;
    alu_Overflow = 1'b0;
    alu_CarryOut = 1'b0;
    if (alu_opi >= 0) begin
      alu_idx = alu_opi * 256 + int'(alu_B) * 16 + int'(alu_A);
      alu_r   = force_en[alu_idx] ? int'(force_val[alu_idx])
                                  : gold_r(alu_opi, int'(alu_A), int'(alu_B));
      alu_Overflow = gold_v(alu_opi, int'(alu_A), int'(alu_B)) != 0;
      alu_CarryOut = (gold_c(alu_opi, int'(alu_A), int'(alu_B)) != 0) ^ (carry_inv && alu_opi == 3);
    end
    alu_Result = alu_r[3:0];
    alu_Zero   = (alu_r[3:0] == 4'd0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 1280; i++) begin
      force_en[i]  = 1'b0;
      force_val[i] = 4'd0;
    end
    carry_inv = 1'b0;
  endtask

  // Walk the sweep in its defined order and predict what the engine reports.
  task automatic model(output int e_err, output int fa, output int fb, output int fop,
                       output int fres);
    int g, rr, idx;
    bit bad;
    e_err = 0; fa = 0; fb = 0; fop = 0; fres = 0;
    for (int opi = 0; opi < 5; opi++)
      for (int b = 0; b < 16; b++)
        for (int a = 0; a < 16; a++) begin
          idx = opi * 256 + b * 16 + a;
          g   = gold_r(opi, a, b);
          rr  = force_en[idx] ? int'(force_val[idx]) : g;
          bad = (rr != g);
`ifdef ALU_BIST_FLAG_CHECK_EN
          if (carry_inv && opi == 3) bad = 1'b1;
`endif
          if (bad) begin
            if (e_err == 0) begin
              fa = a; fb = b; fop = op_code(opi); fres = rr;
            end
            e_err++;
          end
        end
  endtask

  task automatic run_sweep(input string tag, input bit glitch, input int e_err, input int e_fa,
                           input int e_fb, input int e_fop, input int e_fres, input int e_pass);
    int n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_done_clr"}, int'(done), 0);
    chk({tag, "_err_clr"}, int'(err_count), 0);
    n = 0;
    while (busy && n < 6000) begin
      n++;
      start = glitch && (n == 100 || n == 2000);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_len"}, n, 3840);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_pass"}, int'(pass), e_pass);
    chk({tag, "_err_count"}, int'(err_count), e_err);
    if (e_err > 0) begin
      chk({tag, "_fail_A"}, int'(fail_A), e_fa);
      chk({tag, "_fail_B"}, int'(fail_B), e_fb);
      chk({tag, "_fail_op"}, int'(fail_op), e_fop);
      chk({tag, "_fail_result"}, int'(fail_result), e_fres);
    end
  endtask

  typedef struct {
    string name;
    int    fidx;
    int    fval;
    bit    cinv;
    bit    glitch;
    int    e_err, e_fa, e_fb, e_fop, e_fres, e_pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int e_err, fa, fb, fop, fres, nf, idx;

    tbl[0] = '{"clean",      -1,   0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{"add_3_2",    547,  0, 1'b0, 1'b0, 1, 3, 2, 2, 0, 0};
    tbl[2] = '{"slt_8_7",    1144, 0, 1'b0, 1'b0, 1, 8, 7, 7, 0, 0};
`ifdef ALU_BIST_FLAG_CHECK_EN
    tbl[3] = '{"sub_cinv",   -1,   0, 1'b1, 1'b0, 256, 0, 0, 6, 0, 0};
`else
    tbl[3] = '{"sub_cinv",   -1,   0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1};
`endif
    tbl[4] = '{"start_glitch", -1, 0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1};

    clear_faults();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_alu_vec", int'({alu_A, alu_B, alu_ALUop}), 0);
    chk("rst_fail_vec", int'({fail_A, fail_B, fail_op, fail_result}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      clear_faults();
      if (tbl[i].fidx >= 0) begin
        force_en[tbl[i].fidx]  = 1'b1;
        force_val[tbl[i].fidx] = tbl[i].fval[3:0];
      end
      carry_inv = tbl[i].cinv;
      run_sweep(tbl[i].name, tbl[i].glitch, tbl[i].e_err, tbl[i].e_fa, tbl[i].e_fb,
                tbl[i].e_fop, tbl[i].e_fres, tbl[i].e_pass);
    end

    for (int r = 0; r < 3; r++) begin
      clear_faults();
      nf = $urandom_range(1, 4);
      for (int k = 0; k < nf; k++) begin
        idx = $urandom_range(0, 1279);
        force_en[idx]  = 1'b1;
        force_val[idx] = 4'($urandom_range(0, 15));
      end
      carry_inv = ($urandom_range(0, 1) == 1);
      model(e_err, fa, fb, fop, fres);
      run_sweep($sformatf("rand%0d", r), 1'b0, e_err, fa, fb, fop, fres, (e_err == 0) ? 1 : 0);
    end

    // Abort mid-sweep after an error has already been latched.
    clear_faults();
    force_en[5]  = 1'b1;
    force_val[5] = 4'd1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (499) @(negedge clk);
    chk("pre_abort_err", int'(err_count), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_err_count", int'(err_count), 0);
    chk("abort_alu_vec", int'({alu_A, alu_B, alu_ALUop}), 0);
    chk("abort_fail_vec", int'({fail_A, fail_B, fail_op, fail_result}), 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    clear_faults();
    run_sweep("post_abort", 1'b0, 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
